// File: rtl/fp32_seq_divider.sv
// Sequential IEEE 754 single-precision divider: restoring division, one quotient bit per cycle,
// round-to-nearest-even, denormals flushed to zero, fixed 27-cycle latency.
module fp32_seq_divider (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] y,
   output logic [3:0]  flags
);

   typedef enum logic [1:0] {StIdle, StDiv, StRound, StDone} state_e;

   state_e      state_q;
   logic [30:0] a_q, b_q;
   logic        sign_q;
   logic [4:0]  cnt_q;
   logic [25:0] quo_q, rem_q;
   logic [31:0] y_q;
   logic [3:0]  flags_q;
   logic        in_ready_q, out_valid_q;

   // One restoring-division step on the registered partial remainder.
   logic [25:0] divisor, diff, quo_d, rem_d;
   logic        qbit;

   always_comb begin
      divisor = {2'b00, |b_q[30:23], b_q[22:0]};
      qbit    = (rem_q >= divisor);
      diff    = qbit ? (rem_q - divisor) : rem_q;
      rem_d   = {diff[24:0], 1'b0};
      quo_d   = {quo_q[24:0], qbit};
   end

   logic signed [9:0] exp_a, exp_b, exp_n, exp_f;
   logic [22:0] frac, frac_r;
   logic        guard, sticky, rnd_up, carry;
   logic        a_max, b_max, a_zero, b_zero, a_nan, b_nan, a_inf, b_inf;
   logic [31:0] y_d;
   logic [3:0]  flags_d;

   always_comb begin
      exp_a = signed'({2'b00, a_q[30:23]});
      exp_b = signed'({2'b00, b_q[30:23]});
      if (quo_q[25]) begin
         frac   = quo_q[24:2];
         guard  = quo_q[1];
         sticky = quo_q[0] | (|rem_q);
         exp_n  = exp_a - exp_b + 10'sd127;
      end else begin
         frac   = quo_q[23:1];
         guard  = quo_q[0];
         sticky = |rem_q;
         exp_n  = exp_a - exp_b + 10'sd126;
      end
      rnd_up = guard & (sticky | frac[0]);
      // The hidden bit is always set, so a carry out of the significand needs an all-ones fraction.
      carry  = rnd_up & (&frac);
      frac_r = frac + {22'd0, rnd_up};
      exp_f  = carry ? (exp_n + 10'sd1) : exp_n;

      a_max  = &a_q[30:23];
      b_max  = &b_q[30:23];
      a_zero = ~|a_q[30:23];
      b_zero = ~|b_q[30:23];
      a_nan  = a_max & (|a_q[22:0]);
      b_nan  = b_max & (|b_q[22:0]);
      a_inf  = a_max & ~|a_q[22:0];
      b_inf  = b_max & ~|b_q[22:0];

      y_d     = {sign_q, exp_f[7:0], frac_r};
      flags_d = {3'b000, guard | sticky};
      if (exp_f >= 10'sd255) begin
         y_d     = {sign_q, 8'hFF, 23'd0};
         flags_d = 4'b0101;
      end else if (exp_f <= 10'sd0) begin
         y_d     = {sign_q, 31'd0};
         flags_d = 4'b0011;
      end

      if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
         y_d     = 32'h7FC0_0000;
         flags_d = 4'b0000;
      end else if (a_inf) begin
         y_d     = {sign_q, 8'hFF, 23'd0};
         flags_d = 4'b0000;
      end else if (b_zero) begin
         y_d     = {sign_q, 8'hFF, 23'd0};
         flags_d = 4'b1000;
      end else if (a_zero | b_inf) begin
         y_d     = {sign_q, 31'd0};
         flags_d = 4'b0000;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         a_q         <= '0;
         b_q         <= '0;
         sign_q      <= 1'b0;
         cnt_q       <= '0;
         quo_q       <= '0;
         rem_q       <= '0;
         y_q         <= '0;
         flags_q     <= '0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (in_valid) begin
                  a_q        <= a[30:0];
                  b_q        <= b[30:0];
                  sign_q     <= a[31] ^ b[31];
                  cnt_q      <= 5'd25;
                  quo_q      <= '0;
                  rem_q      <= {2'b00, |a[30:23], a[22:0]};
                  in_ready_q <= 1'b0;
                  state_q    <= StDiv;
               end
            end
            StDiv: begin
               quo_q <= quo_d;
               rem_q <= rem_d;
               if (cnt_q == 5'd0) begin
                  state_q <= StRound;
               end else begin
                  cnt_q <= cnt_q - 5'd1;
               end
            end
            StRound: begin
               y_q         <= y_d;
               flags_q     <= flags_d;
               out_valid_q <= 1'b1;
               state_q     <= StDone;
            end
            StDone: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  state_q     <= StIdle;
               end
            end
         endcase
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign flags     = flags_q;

endmodule

// File: tb/tb_fp32_seq_divider.sv
// Randomised bench for fp32_seq_divider, checked every cycle against an arithmetic reference model.
module tb_fp32_seq_divider;

   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready, in_ready, out_valid;
   logic [31:0] a, b, y;
   logic [3:0]  flags;

   int checks = 0;
   int errors = 0;

   // Model state: 0 idle, 1 busy, 2 result pending.
   int          m_st = 0;
   int          m_cnt = 0;
   logic [35:0] exp_q[$];

   always #5 clk = ~clk;

   fp32_seq_divider dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .flags     (flags)
   );

   task automatic check(input string name, input logic [35:0] act, input logic [35:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
      end
   endtask

   // Returns {flags, y}, computed with wide integer division of the significands.
   function automatic logic [35:0] ref_div(input logic [31:0] av, input logic [31:0] bv);
      int ea, eb, e;
      longint unsigned ma, mb, q, r, mant, rest, half;
      logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inx, up;
      logic [31:0] ev;
      ea     = int'(av[30:23]);
      eb     = int'(bv[30:23]);
      s      = av[31] ^ bv[31];
      a_nan  = (ea == 255) && (av[22:0] != 0);
      b_nan  = (eb == 255) && (bv[22:0] != 0);
      a_inf  = (ea == 255) && (av[22:0] == 0);
      b_inf  = (eb == 255) && (bv[22:0] == 0);
      a_zero = (ea == 0);
      b_zero = (eb == 0);
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) return {4'b0000, 32'h7FC00000};
      if (a_inf) return {4'b0000, s, 8'hFF, 23'd0};
      if (b_zero) return {4'b1000, s, 8'hFF, 23'd0};
      if (a_zero || b_inf) return {4'b0000, s, 31'd0};
      ma = {40'd0, 1'b1, av[22:0]};
      mb = {40'd0, 1'b1, bv[22:0]};
      q  = (ma << 38) / mb;
      r  = (ma << 38) % mb;
      if (q >= (64'd1 << 38)) begin
         e = ea - eb + 127; mant = q >> 15; rest = q & 64'h7FFF; half = 64'h4000;
      end else begin
         e = ea - eb + 126; mant = q >> 14; rest = q & 64'h3FFF; half = 64'h2000;
      end
      inx = (rest != 0) || (r != 0);
      up  = (rest > half) || ((rest == half) && ((r != 0) || mant[0]));
      mant = mant + {63'd0, up};
      if (mant == (64'd1 << 24)) begin
         mant = 64'd1 << 23;
         e = e + 1;
      end
      if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
      if (e <= 0) return {4'b0011, s, 31'd0};
      ev = e;
      return {3'b000, inx, s, ev[7:0], mant[22:0]};
   endfunction

   function automatic logic [31:0] rand_fp();
      int unsigned k;
      logic [31:0] v;
      k = $urandom_range(0, 15);
      v = $urandom;
      case (k)
         0:       v[30:23] = 8'h00;
         1:       begin v[30:23] = 8'hFF; v[22:0] = 23'd0; end
         2:       begin v[30:23] = 8'hFF; v[22] = 1'b1; end
         3:       begin v[30:23] = 8'($urandom_range(1, 254)); v[22:0] = 23'd0; end
         4:       begin v[30:23] = 8'($urandom_range(1, 254)); v[22:0] = '1; end
         5, 6, 7, 8, 9: v[30:23] = 8'($urandom_range(100, 154));
         default: v[30:23] = 8'($urandom_range(1, 254));
      endcase
      return v;
   endfunction

   // Cycle-level model: accept in idle, result visible 27 edges later, held until out_ready.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_st  <= 0;
         m_cnt <= 0;
         exp_q.delete();
      end else begin
         case (m_st)
            0: if (in_valid) begin
               exp_q.push_back(ref_div(a, b));
               m_cnt <= 27;
               m_st  <= 1;
            end
            1: begin
               m_cnt <= m_cnt - 1;
               if (m_cnt == 1) m_st <= 2;
            end
            default: if (out_ready) begin
               void'(exp_q.pop_front());
               m_st <= 0;
            end
         endcase
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst) begin
         check("in_ready", {35'd0, in_ready}, {35'd0, m_st == 0});
         check("out_valid", {35'd0, out_valid}, {35'd0, m_st == 2});
         if (m_st == 2 && exp_q.size() > 0) check("result", {flags, y}, exp_q[0]);
      end
   end

   task automatic run_op(input logic [31:0] av, input logic [31:0] bv, input int hold,
                         input bit pulse, input bit chk_lit, input logic [35:0] lit);
      int n;
      n = 0;
      while (m_st != 0 && n < 100) begin @(negedge clk); n++; end
      if (m_st != 0) begin
         checks++; errors++;
         $display("FAIL idle_timeout: state %0d want 0", m_st);
         return;
      end
      a = av; b = bv; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0; a = $urandom; b = $urandom;
      if (pulse) begin
         repeat (5) @(negedge clk);
         in_valid = 1'b1; a = rand_fp(); b = rand_fp();
         @(negedge clk);
         in_valid = 1'b0;
      end
      n = 0;
      while (m_st != 2 && n < 60) begin @(negedge clk); n++; end
      if (m_st != 2) begin
         checks++; errors++;
         $display("FAIL done_timeout: state %0d want 2", m_st);
         return;
      end
      repeat (hold) @(negedge clk);
      if (chk_lit) check("literal", {flags, y}, lit);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
      #1;
      check("rst_in_ready", {35'd0, in_ready}, 36'd1);
      check("rst_out_valid", {35'd0, out_valid}, 36'd0);
      check("rst_y_flags", {flags, y}, 36'd0);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;

      check("pin_6_2", ref_div(32'h40C00000, 32'h40000000), {4'b0000, 32'h40400000});
      check("pin_1_3", ref_div(32'h3F800000, 32'h40400000), {4'b0001, 32'h3EAAAAAB});
      check("pin_neg", ref_div(32'hC0C00000, 32'h40000000), {4'b0000, 32'hC0400000});
      check("pin_dbz", ref_div(32'h3F800000, 32'h00000000), {4'b1000, 32'h7F800000});
      check("pin_0_0", ref_div(32'h00000000, 32'h00000000), {4'b0000, 32'h7FC00000});
      check("pin_ovf", ref_div(32'h7F000000, 32'h3E800000), {4'b0101, 32'h7F800000});
      check("pin_unf", ref_div(32'h00800000, 32'h40000000), {4'b0011, 32'h00000000});

      run_op(32'h40C00000, 32'h40000000, 0, 1'b0, 1'b1, {4'b0000, 32'h40400000});
      run_op(32'h3F800000, 32'h40400000, 1, 1'b0, 1'b1, {4'b0001, 32'h3EAAAAAB});
      run_op(32'hC0C00000, 32'h40000000, 0, 1'b0, 1'b1, {4'b0000, 32'hC0400000});
      run_op(32'h3F800000, 32'h00000000, 2, 1'b0, 1'b1, {4'b1000, 32'h7F800000});
      run_op(32'h00000000, 32'h00000000, 0, 1'b0, 1'b1, {4'b0000, 32'h7FC00000});
      run_op(32'h00000000, 32'h40A00000, 0, 1'b0, 1'b1, {4'b0000, 32'h00000000});
      run_op(32'h7F000000, 32'h3E800000, 0, 1'b0, 1'b1, {4'b0101, 32'h7F800000});
      run_op(32'h00800000, 32'h40000000, 0, 1'b0, 1'b1, {4'b0011, 32'h00000000});
      // Long stall in DONE plus an in_valid pulse while dividing.
      run_op(32'h40C00000, 32'h40000000, 10, 1'b1, 1'b1, {4'b0000, 32'h40400000});

      for (int i = 0; i < 150; i++) begin
         run_op(rand_fp(), rand_fp(), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                1'b0, 36'd0);
      end

      // Reset in the middle of a division.
      run_op(32'h3F800000, 32'h40400000, 0, 1'b0, 1'b1, {4'b0001, 32'h3EAAAAAB});
      a = 32'h3F800000; b = 32'h40400000; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (12) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check("midrst_in_ready", {35'd0, in_ready}, 36'd1);
      check("midrst_out_valid", {35'd0, out_valid}, 36'd0);
      check("midrst_y_flags", {flags, y}, 36'd0);
      @(posedge clk);
      #2 rst = 1'b0;
      run_op(32'h40C00000, 32'h40000000, 0, 1'b0, 1'b1, {4'b0000, 32'h40400000});
      repeat (3) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
